// File: rtl/receiver_spi.sv
// SPI slave receiver: 2-FF synchronised SCK/CS/MOSI, LSB-first WIDTH-bit words,
// parallel-loaded MISO return word, daisy-chainable as a WIDTH-bit shift stage.
`timescale 1ns/1ps
module receiver_spi #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CKP,
    input  logic             CPH,
    input  logic             SCK,
    input  logic             CS,
    input  logic             MOSI,
    input  logic [WIDTH-1:0] data_in,
    output logic             MISO,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             frame_err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic [2:0]       sck_q, sck_d;
    logic [2:0]       cs_q, cs_d;
    logic [1:0]       mosi_q, mosi_d;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rx_bit_q, rx_bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             miso_q, miso_d;
    logic             data_valid_q, data_valid_d;
    logic             busy_q, busy_d;
    logic             frame_err_q, frame_err_d;
    logic             first_q, first_d;
    logic             armed_q, armed_d;
    logic [1:0]       settle_q, settle_d;

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge, mosi_s;

    always_comb begin
        sck_d  = {sck_q[1:0], SCK};
        cs_d   = {cs_q[1:0], CS};
        mosi_d = {mosi_q[0], MOSI};
    end

    assign sck_rise    = sck_q[1] & ~sck_q[2];
    assign sck_fall    = ~sck_q[1] & sck_q[2];
    assign cs_rise     = cs_q[1] & ~cs_q[2];
    assign cs_fall     = ~cs_q[1] & cs_q[2];
    assign lead_edge   = CKP ? sck_fall : sck_rise;
    assign trail_edge  = CKP ? sck_rise : sck_fall;
    assign sample_edge = CPH ? trail_edge : lead_edge;
    assign shift_edge  = CPH ? lead_edge : trail_edge;
    assign mosi_s      = mosi_q[1];

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        data_out_d   = data_out_q;
        rx_bit_d     = rx_bit_q;
        cnt_d        = cnt_q;
        miso_d       = miso_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        first_d      = first_q;
        settle_d     = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        // After reset the synchroniser holds forced idle levels for two cycles;
        // a frame may only start once the real CS has been seen high.
        armed_d      = armed_q | ((settle_q >= 2'd2) & cs_q[1]);

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                cnt_d  = '0;
                if (armed_q && cs_fall) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shreg_d = data_in;
                miso_d  = data_in[0];
                first_d = 1'b1;
                state_d = cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                    miso_d      = 1'b0;
                    cnt_d       = '0;
                end else begin
                    if (sample_edge) begin
                        rx_bit_d = mosi_s;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            data_out_d   = {mosi_s, shreg_q[WIDTH-1:1]};
                            data_valid_d = 1'b1;
                            cnt_d        = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    // With CPH=1 the first leading edge only opens the bit window.
                    if (shift_edge) begin
                        if (CPH && first_q) begin
                            first_d = 1'b0;
                        end else begin
                            first_d = 1'b0;
                            shreg_d = {rx_bit_q, shreg_q[WIDTH-1:1]};
                            miso_d  = shreg_q[1];
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q        <= {3{CKP}};
            cs_q         <= 3'b111;
            mosi_q       <= 2'b00;
            state_q      <= IDLE;
            shreg_q      <= '0;
            data_out_q   <= '0;
            rx_bit_q     <= 1'b0;
            cnt_q        <= '0;
            miso_q       <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            first_q      <= 1'b0;
            armed_q      <= 1'b0;
            settle_q     <= 2'd0;
        end else begin
            sck_q        <= sck_d;
            cs_q         <= cs_d;
            mosi_q       <= mosi_d;
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            data_out_q   <= data_out_d;
            rx_bit_q     <= rx_bit_d;
            cnt_q        <= cnt_d;
            miso_q       <= miso_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            first_q      <= first_d;
            armed_q      <= armed_d;
            settle_q     <= settle_d;
        end
    end

    assign MISO       = miso_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_receiver_spi.sv
// Bench for receiver_spi: two stages chained on one SPI link, driven by a
// behavioural SPI master and checked against a bit-stream model of the chain.
`timescale 1ns/1ps
module tb_receiver_spi;
    localparam int H = 3;

    logic        clk = 1'b0;
    logic        rst, CKP, CPH, SCK, CS, MOSI;
    logic [15:0] din0, din1;
    logic        miso0, miso1, dv0, dv1, busy0, busy1, fe0, fe1;
    logic [15:0] dout0, dout1;
    logic        chain;
    logic        miso_m;

    int checks = 0;
    int errors = 0;
    int fe_cnt0 = 0;
    int fe_cnt1 = 0;
    logic [15:0] got_q0[$], got_q1[$], exp_q0[$], exp_q1[$];
    logic [15:0] last_d0, last_d1;

    typedef struct {
        logic        ckp;
        logic        cph;
        logic        chain;
        int          nbits;
        logic [15:0] ld0;
        logic [15:0] ld1;
        logic [31:0] tx;
        logic [31:0] exp_rx;
        logic [15:0] d0a;
        logic [15:0] d0b;
        logic [15:0] d1a;
        logic [15:0] d1b;
        int          nv;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign miso_m = chain ? miso1 : miso0;

    receiver_spi #(.WIDTH(16)) u_stage0 (
        .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
        .MOSI(MOSI), .data_in(din0), .MISO(miso0), .data_out(dout0),
        .data_valid(dv0), .busy(busy0), .frame_err(fe0)
    );

    receiver_spi #(.WIDTH(16)) u_stage1 (
        .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
        .MOSI(miso0), .data_in(din1), .MISO(miso1), .data_out(dout1),
        .data_valid(dv1), .busy(busy1), .frame_err(fe1)
    );

    always @(negedge clk) begin
        if (dv0) got_q0.push_back(dout0);
        if (dv1) got_q1.push_back(dout1);
        if (fe0) fe_cnt0 <= fe_cnt0 + 1;
        if (fe1) fe_cnt1 <= fe_cnt1 + 1;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_mode(input logic ckp, input logic cph);
        @(negedge clk);
        CKP = ckp;
        CPH = cph;
        SCK = ckp;
        repeat (4) @(negedge clk);
    endtask

    // SPI master: drives nbits LSB-first, captures MISO on the master's sample edge.
    task automatic spi_frame(input int nbits, input logic [31:0] tx, input int rst_after,
                             output logic [31:0] rx);
        rx = '0;
        @(negedge clk);
        SCK = CKP;
        CS  = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (!CPH) begin
                MOSI = tx[i];
                repeat (H) @(negedge clk);
                rx[i] = miso_m;
                SCK   = ~CKP;
                repeat (H) @(negedge clk);
                SCK = CKP;
            end else begin
                MOSI = tx[i];
                SCK  = ~CKP;
                repeat (H) @(negedge clk);
                rx[i] = miso_m;
                SCK   = CKP;
                repeat (H) @(negedge clk);
            end
            if (i == rst_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_outs0", {11'd0, miso0, dv0, busy0, fe0, dout0}, 32'd0);
                check("rst_outs1", {11'd0, miso1, dv1, busy1, fe1, dout1}, 32'd0);
            end
        end
        repeat (H) @(negedge clk);
        CS = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Chain model: each stage emits its preload, then whatever it received,
    // and reports every complete 16-bit chunk of its input stream.
    task automatic model_frame(input int nbits, input logic [31:0] tx, input logic [15:0] ld0,
                               input logic [15:0] ld1, input logic ch, output logic [31:0] exp_rx);
        logic [31:0] out0, out1;
        out0 = '0;
        out1 = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 16) begin
                out0[i] = ld0[i];
                out1[i] = ld1[i];
            end else begin
                out0[i] = tx[i-16];
                out1[i] = out0[i-16];
            end
        end
        for (int w = 0; w < nbits / 16; w++) begin
            exp_q0.push_back(tx[w*16 +: 16]);
            exp_q1.push_back(out0[w*16 +: 16]);
            last_d0 = tx[w*16 +: 16];
            last_d1 = out0[w*16 +: 16];
        end
        exp_rx = ch ? out1 : out0;
    endtask

    task automatic compare_queues(input string tag);
        logic [15:0] g;
        check({tag, "_nvalid0"}, 32'(got_q0.size()), 32'(exp_q0.size()));
        check({tag, "_nvalid1"}, 32'(got_q1.size()), 32'(exp_q1.size()));
        while (exp_q0.size() > 0) begin
            g = (got_q0.size() > 0) ? got_q0.pop_front() : 'x;
            check({tag, "_dout0"}, {16'd0, g}, {16'd0, exp_q0.pop_front()});
        end
        while (exp_q1.size() > 0) begin
            g = (got_q1.size() > 0) ? got_q1.pop_front() : 'x;
            check({tag, "_dout1"}, {16'd0, g}, {16'd0, exp_q1.pop_front()});
        end
        got_q0.delete();
        got_q1.delete();
    endtask

    initial begin
        logic [31:0] rx, exp_rx, tx;
        logic [15:0] ld0, ld1;
        int          fe_base0, fe_base1, nbits;

        rst = 1'b1; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
        din0 = '0; din1 = '0; chain = 1'b0; last_d0 = '0; last_d1 = '0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 16, 16'hA5C3, 16'h0000, 32'h0000_1234, 32'h0000_A5C3,
                    16'h1234, 16'h0000, 16'hA5C3, 16'h0000, 1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32, 16'h1111, 16'h2222, 32'h0F0F_BEEF, 32'h1111_2222,
                    16'hBEEF, 16'h0F0F, 16'h1111, 16'hBEEF, 2};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16, 16'h8001, 16'h3C3C, 32'h0000_7FFE, 32'h0000_8001,
                    16'h7FFE, 16'h0000, 16'h8001, 16'h0000, 1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16, 16'hFFFF, 16'h0000, 32'h0000_0000, 32'h0000_0000,
                    16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 32, 16'hABCD, 16'h1357, 32'h9876_5432, 32'hABCD_1357,
                    16'h5432, 16'h9876, 16'hABCD, 16'h5432, 2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso", {31'd0, miso0}, 32'd0);
        check("reset_data_out", {16'd0, dout0}, 32'd0);
        check("reset_data_valid", {31'd0, dv0}, 32'd0);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_frame_err", {31'd0, fe0}, 32'd0);
        repeat (4) @(negedge clk);

        // Directed table
        for (int v = 0; v < 5; v++) begin
            set_mode(vecs[v].ckp, vecs[v].cph);
            din0  = vecs[v].ld0;
            din1  = vecs[v].ld1;
            chain = vecs[v].chain;
            got_q0.delete();
            got_q1.delete();
            fe_base0 = fe_cnt0;
            fe_base1 = fe_cnt1;
            exp_q0.push_back(vecs[v].d0a);
            exp_q1.push_back(vecs[v].d1a);
            last_d0 = vecs[v].d0a;
            last_d1 = vecs[v].d1a;
            if (vecs[v].nv == 2) begin
                exp_q0.push_back(vecs[v].d0b);
                exp_q1.push_back(vecs[v].d1b);
                last_d0 = vecs[v].d0b;
                last_d1 = vecs[v].d1b;
            end
            spi_frame(vecs[v].nbits, vecs[v].tx, -1, rx);
            check($sformatf("vec%0d_rx", v), rx, vecs[v].exp_rx);
            compare_queues($sformatf("vec%0d", v));
            check($sformatf("vec%0d_frame_err", v), 32'(fe_cnt0 - fe_base0 + fe_cnt1 - fe_base1), 32'd0);
        end

        // Partial frame: 9 bits then CS rise
        set_mode(1'b0, 1'b0);
        chain = 1'b0;
        got_q0.delete();
        got_q1.delete();
        fe_base0 = fe_cnt0;
        fe_base1 = fe_cnt1;
        spi_frame(9, 32'h0000_01A5, -1, rx);
        check("partial_busy", {31'd0, busy0}, 32'd0);
        check("partial_frame_err0", 32'(fe_cnt0 - fe_base0), 32'd1);
        check("partial_frame_err1", 32'(fe_cnt1 - fe_base1), 32'd1);
        check("partial_nvalid", 32'(got_q0.size() + got_q1.size()), 32'd0);
        check("partial_hold0", {16'd0, dout0}, {16'd0, last_d0});
        check("partial_hold1", {16'd0, dout1}, {16'd0, last_d1});
        repeat (3) @(negedge clk);

        // Reset after 7 bits aborts the frame silently
        got_q0.delete();
        got_q1.delete();
        fe_base0 = fe_cnt0;
        fe_base1 = fe_cnt1;
        spi_frame(16, 32'h0000_C0DE, 6, rx);
        check("rst_nvalid", 32'(got_q0.size() + got_q1.size()), 32'd0);
        check("rst_frame_err", 32'(fe_cnt0 - fe_base0 + fe_cnt1 - fe_base1), 32'd0);
        check("rst_dout_after", {16'd0, dout0}, 32'd0);
        din0 = 16'h5A5A;
        din1 = 16'h0FF0;
        model_frame(16, 32'h0000_6B2D, din0, din1, chain, exp_rx);
        spi_frame(16, 32'h0000_6B2D, -1, rx);
        check("post_rst_rx", rx, exp_rx);
        compare_queues("post_rst");

        // CS held high while SCK toggles
        got_q0.delete();
        got_q1.delete();
        for (int t = 0; t < 20; t++) begin
            SCK  = ~SCK;
            MOSI = 1'($urandom);
            repeat (H) @(negedge clk);
            check("cs_high_idle", {28'd0, miso0, busy0, miso1, busy1}, 32'd0);
        end
        SCK = CKP;
        repeat (4) @(negedge clk);
        check("cs_high_nvalid", 32'(got_q0.size() + got_q1.size()), 32'd0);

        // Randomised frames in all four modes
        for (int m = 0; m < 4; m++) begin
            set_mode(m[1], m[0]);
            for (int f = 0; f < 100; f++) begin
                ld0   = 16'($urandom);
                ld1   = 16'($urandom);
                tx    = $urandom;
                nbits = ($urandom_range(0, 3) == 0) ? 32 : 16;
                chain = 1'($urandom_range(0, 1));
                din0  = ld0;
                din1  = ld1;
                got_q0.delete();
                got_q1.delete();
                fe_base0 = fe_cnt0;
                fe_base1 = fe_cnt1;
                model_frame(nbits, tx, ld0, ld1, chain, exp_rx);
                spi_frame(nbits, tx, -1, rx);
                check($sformatf("rand_m%0d_f%0d_rx", m, f), rx, exp_rx);
                compare_queues($sformatf("rand_m%0d_f%0d", m, f));
                check($sformatf("rand_m%0d_f%0d_ferr", m, f),
                      32'(fe_cnt0 - fe_base0 + fe_cnt1 - fe_base1), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
